// File: rtl/lexington_pkg.sv
// Shared RV32 word types and lexington memory-subsystem constants and types.
package rv32;
  localparam int unsigned XLEN = 32;
  typedef logic [XLEN-1:0] word;
endpackage

package lexington;
  localparam int unsigned DEFAULT_RAM_ADDR_WIDTH = 10;
  localparam int unsigned RAM_MAX_RD_LATENCY     = 2;

  typedef enum logic {
    RAM_READ_FIRST,
    RAM_WRITE_FIRST
  } ram_collision_t;
endpackage

// File: rtl/ram_rd_pipe.sv
// Per-port read pipeline for ram_dual: data/valid register chain, write-first bypass
// and, with RAM_PARITY_EN defined, a sticky per-byte parity check on the first stage.
module ram_rd_pipe
  import rv32::*, lexington::*;
#(
  parameter int unsigned    RD_LATENCY = 1,
  parameter ram_collision_t COLLISION  = RAM_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [XLEN-1:0]     rd_word,
  input  logic                wr_hit,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [XLEN/8-1:0]   wr_strobe,
`ifdef RAM_PARITY_EN
  input  logic [XLEN/8-1:0]   rd_par,
  output logic                parity_err,
`endif
  output logic [XLEN-1:0]     rd_data,
  output logic                rd_valid
);
  localparam int unsigned NB = XLEN / 8;

  logic            s1_valid;
  logic            s1_hit;
  logic [XLEN-1:0] s1_word;
  logic [XLEN-1:0] s1_wdata;
  logic [NB-1:0]   s1_strb;
  logic [NB-1:0]   byp_lanes;
  logic [XLEN-1:0] merged;

  // Stage-1 registers only load on a request, so the output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_word  <= '0;
      s1_wdata <= '0;
      s1_strb  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_word  <= rd_word;
        s1_hit   <= wr_hit;
        s1_wdata <= wr_data;
        s1_strb  <= wr_strobe;
      end
    end
  end

  // Write-first: the colliding write's strobed lanes bypass the pre-write array word.
  always_comb begin
    byp_lanes = (COLLISION == RAM_WRITE_FIRST && s1_hit) ? s1_strb : '0;
    merged    = s1_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (byp_lanes[i]) merged[i*8 +: 8] = s1_wdata[i*8 +: 8];
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data  = merged;
    assign rd_valid = s1_valid;
  end else begin : g_lat2
    logic [XLEN-1:0] s2_data;
    logic            s2_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= merged;
      end
    end

    assign rd_data  = s2_data;
    assign rd_valid = s2_valid;
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] s1_par;
  logic [NB-1:0] par_calc;

  always_ff @(posedge clk) begin
    if (rst)        s1_par <= '0;
    else if (rd_en) s1_par <= rd_par;
  end

  always_comb begin
    par_calc = '0;
    for (int unsigned i = 0; i < NB; i++) par_calc[i] = ^s1_word[i*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst)                                 parity_err <= 1'b0;
    else if (s1_valid && (par_calc != s1_par)) parity_err <= 1'b1;
  end
`endif
endmodule

// File: rtl/ram_dual.sv
// Dual-port byte-writable RAM: port A read-only, port B read/write, registered reads.
// Optional per-byte even parity with sticky error flag when RAM_PARITY_EN is defined.
module ram_dual
  import rv32::*, lexington::*;
#(
  parameter int unsigned    ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
  parameter int unsigned    RD_LATENCY = 1,
  parameter ram_collision_t COLLISION  = RAM_READ_FIRST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_rd_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [XLEN-1:0]       a_rd_data,
  output logic                  a_rd_valid,
  input  logic                  b_rd_en,
  input  logic                  b_wr_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [XLEN-1:0]       b_wr_data,
  input  logic [XLEN/8-1:0]     b_wr_strobe,
`ifdef RAM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic [XLEN-1:0]       b_rd_data,
  output logic                  b_rd_valid
);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (RD_LATENCY < 1 || RD_LATENCY > RAM_MAX_RD_LATENCY) begin : g_bad_latency
    $error("ram_dual: RD_LATENCY must be 1 or 2");
  end

  logic [XLEN-1:0] mem [DEPTH];
  logic            a_hit;

  always_ff @(posedge clk) begin
    if (!rst && b_wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (b_wr_strobe[i]) mem[b_addr][i*8 +: 8] <= b_wr_data[i*8 +: 8];
      end
    end
  end

  assign a_hit = b_wr_en && (a_addr == b_addr);

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic          err_a;
  logic          err_b;

  always_ff @(posedge clk) begin
    if (!rst && b_wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (b_wr_strobe[i]) par_mem[b_addr][i] <= ^b_wr_data[i*8 +: 8];
      end
    end
  end

  assign parity_err = err_a | err_b;
`endif

  (* keep_hierarchy = "yes" *)
  ram_rd_pipe #(.RD_LATENCY(RD_LATENCY), .COLLISION(COLLISION)) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (a_rd_en),
    .rd_word   (mem[a_addr]),
    .wr_hit    (a_hit),
    .wr_data   (b_wr_data),
    .wr_strobe (b_wr_strobe),
`ifdef RAM_PARITY_EN
    .rd_par    (par_mem[a_addr]),
    .parity_err(err_a),
`endif
    .rd_data   (a_rd_data),
    .rd_valid  (a_rd_valid)
  );

  (* keep_hierarchy = "yes" *)
  ram_rd_pipe #(.RD_LATENCY(RD_LATENCY), .COLLISION(COLLISION)) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (b_rd_en),
    .rd_word   (mem[b_addr]),
    .wr_hit    (b_wr_en),
    .wr_data   (b_wr_data),
    .wr_strobe (b_wr_strobe),
`ifdef RAM_PARITY_EN
    .rd_par    (par_mem[b_addr]),
    .parity_err(err_b),
`endif
    .rd_data   (b_rd_data),
    .rd_valid  (b_rd_valid)
  );
endmodule

// File: tb/tb_ram_dual.sv
// Bench for ram_dual: a 1-cycle read-first and a 2-cycle write-first instance share stimulus;
// expectations come from a word-array model of the RAM. Parity test needs RAM_PARITY_EN.
module tb_ram_dual;
  import lexington::*;

  localparam int unsigned AW = 4;
  localparam int unsigned NR = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_rd_en, b_rd_en, b_wr_en;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   b_wr_data;
  logic [3:0]    b_wr_strobe;
  logic [31:0]   a1_data, b1_data, a2_data, b2_data;
  logic          a1_valid, b1_valid, a2_valid, b2_valid;
`ifdef RAM_PARITY_EN
  logic          perr1, perr2;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  ram_dual #(.ADDR_WIDTH(AW), .RD_LATENCY(1), .COLLISION(RAM_READ_FIRST)) dut_l1 (
    .clk(clk), .rst(rst), .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rd_data(a1_data),
    .a_rd_valid(a1_valid), .b_rd_en(b_rd_en), .b_wr_en(b_wr_en), .b_addr(b_addr),
    .b_wr_data(b_wr_data), .b_wr_strobe(b_wr_strobe),
`ifdef RAM_PARITY_EN
    .parity_err(perr1),
`endif
    .b_rd_data(b1_data), .b_rd_valid(b1_valid));

  ram_dual #(.ADDR_WIDTH(AW), .RD_LATENCY(2), .COLLISION(RAM_WRITE_FIRST)) dut_l2 (
    .clk(clk), .rst(rst), .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rd_data(a2_data),
    .a_rd_valid(a2_valid), .b_rd_en(b_rd_en), .b_wr_en(b_wr_en), .b_addr(b_addr),
    .b_wr_data(b_wr_data), .b_wr_strobe(b_wr_strobe),
`ifdef RAM_PARITY_EN
    .parity_err(perr2),
`endif
    .b_rd_data(b2_data), .b_rd_valid(b2_valid));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_rd_en = 1'b0; b_rd_en = 1'b0; b_wr_en = 1'b0;
    a_addr = '0; b_addr = '0; b_wr_data = '0; b_wr_strobe = '0;
  endtask

  task automatic wr(input int addr, input logic [31:0] data, input logic [3:0] strb);
    b_wr_en = 1'b1; b_addr = 4'(addr); b_wr_data = data; b_wr_strobe = strb;
    tick();
    if (!rst) model[addr] = merge(model[addr], data, strb);
    b_wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; idle();
    tick(); tick();
    checks++; if ({a1_valid, b1_valid, a2_valid, b2_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0000", {a1_valid, b1_valid, a2_valid, b2_valid}); end
    checks++; if ((a1_data | b1_data | a2_data | b2_data) !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", a1_data, b1_data, a2_data, b2_data); end
`ifdef RAM_PARITY_EN
    checks++; if ({perr1, perr2} !== 2'b00) begin
      errors++; $display("FAIL reset_parity got %b want 00", {perr1, perr2}); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_latency;
    wr(5, 32'hDEADBEEF, 4'hF);
    a_rd_en = 1'b1; a_addr = 4'd5;
    tick(); a_rd_en = 1'b0;
    checks++; if (a1_valid !== 1'b1 || a1_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat1_read got v=%b %h want v=1 deadbeef", a1_valid, a1_data); end
    checks++; if (a2_valid !== 1'b0) begin
      errors++; $display("FAIL lat2_early got v=%b want 0", a2_valid); end
    tick();
    checks++; if (a1_valid !== 1'b0 || a1_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat1_hold got v=%b %h want v=0 deadbeef", a1_valid, a1_data); end
    checks++; if (a2_valid !== 1'b1 || a2_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat2_read got v=%b %h want v=1 deadbeef", a2_valid, a2_data); end
    tick();
    checks++; if (a2_valid !== 1'b0 || a2_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat2_hold got v=%b %h want v=0 deadbeef", a2_valid, a2_data); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ((a1_data | a2_data) !== 32'h0 || {a1_valid, a2_valid} !== 2'b00) begin
      errors++; $display("FAIL rst_clear got %h %h want 0", a1_data, a2_data); end
    // A write while rst is high must not land.
    rst = 1'b1; wr(5, 32'h0, 4'hF); rst = 1'b0;
    b_rd_en = 1'b1; b_addr = 4'd5;
    tick(); b_rd_en = 1'b0;
    checks++; if (b1_valid !== 1'b1 || b1_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_in_rst got %h want deadbeef", b1_data); end
    tick();
  endtask

  task automatic test_strobe;
    wr(3, 32'h11223344, 4'hF);
    wr(3, 32'hAABBCCDD, 4'b0101);
    wr(3, 32'hFFFFFFFF, 4'b0000);
    b_rd_en = 1'b1; b_addr = 4'd3;
    tick(); b_rd_en = 1'b0;
    checks++; if (b1_valid !== 1'b1 || b1_data !== 32'h11BB33DD) begin
      errors++; $display("FAIL strobe_l1 got v=%b %h want v=1 11bb33dd", b1_valid, b1_data); end
    tick();
    checks++; if (b2_valid !== 1'b1 || b2_data !== 32'h11BB33DD) begin
      errors++; $display("FAIL strobe_l2 got v=%b %h want v=1 11bb33dd", b2_valid, b2_data); end
    tick();
  endtask

  task automatic test_collision;
    wr(7, 32'h0, 4'hF);
    a_rd_en = 1'b1; a_addr = 4'd7; b_rd_en = 1'b1;
    wr(7, 32'hCAFEF00D, 4'hF);
    idle();
    checks++; if ({a1_valid, b1_valid} !== 2'b11 || a1_data !== 32'h0 || b1_data !== 32'h0) begin
      errors++; $display("FAIL coll_read_first got %h %h want 0 0", a1_data, b1_data); end
    tick();
    checks++; if ({a2_valid, b2_valid} !== 2'b11 || a2_data !== 32'hCAFEF00D || b2_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL coll_write_first got %h %h want cafef00d", a2_data, b2_data); end
    a_rd_en = 1'b1; a_addr = 4'd7;
    tick(); a_rd_en = 1'b0;
    checks++; if (a1_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL coll_after got %h want cafef00d", a1_data); end
    tick();
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 8; k++) wr(k, 32'(k), 4'hF);
    for (int k = 0; k < 10; k++) begin
      a_rd_en = (k < 8); a_addr = 4'(k);
      tick();
      checks++; if (a2_valid !== (k >= 1 && k <= 8)) begin
        errors++; $display("FAIL b2b_valid k=%0d got %b want %b", k, a2_valid, (k >= 1 && k <= 8)); end
      if (k >= 1 && k <= 8) begin
        checks++; if (a2_data !== 32'(k - 1)) begin
          errors++; $display("FAIL b2b_data k=%0d got %h want %h", k, a2_data, 32'(k - 1)); end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid;
    a_rd_en = 1'b1; a_addr = 4'd3;
    tick(); a_rd_en = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    checks++; if (a2_valid !== 1'b0 || a2_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_0 got v=%b %h want v=0 0", a2_valid, a2_data); end
    tick();
    checks++; if (a2_valid !== 1'b0 || a2_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_1 got v=%b %h want v=0 0", a2_valid, a2_data); end
    rst = 1'b1; a_rd_en = 1'b1; b_rd_en = 1'b1;
    tick(); rst = 1'b0; idle();
    tick();
    checks++; if ({a1_valid, b1_valid, a2_valid, b2_valid} !== 4'b0) begin
      errors++; $display("FAIL rd_in_rst got %b want 0000", {a1_valid, b1_valid, a2_valid, b2_valid}); end
    tick();
    checks++; if ({a2_valid, b2_valid} !== 2'b00) begin
      errors++; $display("FAIL rd_in_rst_l2 got %b want 00", {a2_valid, b2_valid}); end
  endtask

  task automatic test_random;
    logic        req_a [NR];
    logic        req_b [NR];
    logic [31:0] rfa [NR], wfa [NR], rfb [NR], wfb [NR];
    logic [31:0] last1a, last2a;
    logic        seen1a, seen2a;
    seen1a = 1'b0; seen2a = 1'b0; last1a = '0; last2a = '0;
    for (int i = 0; i < 16; i++) wr(i, $urandom, 4'hF);
    for (int c = 0; c < int'(NR); c++) begin
      a_rd_en = 1'($urandom_range(0, 1));
      b_rd_en = 1'($urandom_range(0, 1));
      b_wr_en = 1'($urandom_range(0, 1));
      a_addr = 4'($urandom_range(0, 15));
      b_addr = ($urandom_range(0, 2) == 0) ? a_addr : 4'($urandom_range(0, 15));
      b_wr_data = $urandom; b_wr_strobe = 4'($urandom_range(0, 15));
      req_a[c] = a_rd_en; req_b[c] = b_rd_en;
      rfa[c] = model[a_addr]; rfb[c] = model[b_addr];
      wfa[c] = (b_wr_en && a_addr == b_addr) ? merge(rfa[c], b_wr_data, b_wr_strobe) : rfa[c];
      wfb[c] = b_wr_en ? merge(rfb[c], b_wr_data, b_wr_strobe) : rfb[c];
      tick();
      if (b_wr_en) model[b_addr] = merge(model[b_addr], b_wr_data, b_wr_strobe);
      checks++; if (a1_valid !== req_a[c] || b1_valid !== req_b[c]) begin
        errors++; $display("FAIL rnd_l1_valid c=%0d got %b%b want %b%b", c, a1_valid, b1_valid, req_a[c], req_b[c]); end
      if (req_a[c]) begin seen1a = 1'b1; last1a = rfa[c]; end
      if (seen1a) begin
        checks++; if (a1_data !== last1a) begin
          errors++; $display("FAIL rnd_l1_a c=%0d got %h want %h", c, a1_data, last1a); end
      end
      if (req_b[c]) begin
        checks++; if (b1_data !== rfb[c]) begin
          errors++; $display("FAIL rnd_l1_b c=%0d got %h want %h", c, b1_data, rfb[c]); end
      end
      if (c > 0) begin
        checks++; if (a2_valid !== req_a[c-1] || b2_valid !== req_b[c-1]) begin
          errors++; $display("FAIL rnd_l2_valid c=%0d got %b%b want %b%b", c, a2_valid, b2_valid, req_a[c-1], req_b[c-1]); end
        if (req_a[c-1]) begin seen2a = 1'b1; last2a = wfa[c-1]; end
        if (seen2a) begin
          checks++; if (a2_data !== last2a) begin
            errors++; $display("FAIL rnd_l2_a c=%0d got %h want %h", c, a2_data, last2a); end
        end
        if (req_b[c-1]) begin
          checks++; if (b2_data !== wfb[c-1]) begin
            errors++; $display("FAIL rnd_l2_b c=%0d got %h want %h", c, b2_data, wfb[c-1]); end
        end
      end
    end
    idle(); tick(); tick();
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity;
    rst = 1'b1; tick(); rst = 1'b0;
    wr(9, 32'h000000FF, 4'hF);
    a_rd_en = 1'b1; a_addr = 4'd9; b_rd_en = 1'b1; b_addr = 4'd9;
    tick(); idle(); tick(); tick();
    checks++; if ({perr1, perr2} !== 2'b00) begin
      errors++; $display("FAIL parity_clean got %b want 00", {perr1, perr2}); end
    dut_l1.mem[9] = dut_l1.mem[9] ^ 32'h1;
    dut_l2.mem[9] = dut_l2.mem[9] ^ 32'h1;
    a_rd_en = 1'b1; a_addr = 4'd9;
    tick(); idle(); tick();
    checks++; if ({perr1, perr2} !== 2'b11) begin
      errors++; $display("FAIL parity_detect got %b want 11", {perr1, perr2}); end
    checks++; if (a1_data !== 32'h000000FE) begin
      errors++; $display("FAIL parity_data got %h want 000000fe", a1_data); end
    tick(); tick(); tick();
    checks++; if ({perr1, perr2} !== 2'b11) begin
      errors++; $display("FAIL parity_sticky got %b want 11", {perr1, perr2}); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({perr1, perr2} !== 2'b00) begin
      errors++; $display("FAIL parity_rst got %b want 00", {perr1, perr2}); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_latency();
    test_strobe();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_dual.md
# ram_dual

Dual-port, byte-writable on-chip RAM with registered reads. It is the successor to the single-port combinational-read RAM. Port A is a read-only port for instruction fetch. Port B is a read/write port with byte strobes for the load/store unit. Read latency (1 or 2 cycles) and same-address collision mode are parameters, and optional per-byte parity detects storage corruption.

## Interface
Parameters:
- ADDR_WIDTH, DEFAULT_RAM_ADDR_WIDTH, word-addressable address bits; depth = 2**ADDR_WIDTH words.
- RD_LATENCY, 1, read latency in cycles; legal values are 1 or 2; any other value is an elaboration error.
- COLLISION, RAM_READ_FIRST, same-address behaviour (ram_collision_t): RAM_READ_FIRST returns old data, RAM_WRITE_FIRST returns new data.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset; clears the read pipelines and flags; array contents are not reset.
- a_rd_en  in  1  port A read request.
- a_addr  in  ADDR_WIDTH  port A word address.
- a_rd_data  out  rv32::word  port A read data.
- a_rd_valid  out  1  one-cycle pulse; a_rd_data is valid.
- b_rd_en  in  1  port B read request.
- b_wr_en  in  1  port B write request.
- b_addr  in  ADDR_WIDTH  port B word address.
- b_wr_data  in  rv32::word  port B write data.
- b_wr_strobe  in  XLEN/8  byte-lane write enables.
- b_rd_data  out  rv32::word  port B read data.
- b_rd_valid  out  1  one-cycle pulse; b_rd_data is valid.
- parity_err  out  1  present only with RAM_PARITY_EN; sticky error flag.

## Operation
- Write: when b_wr_en is high and rst is low, each byte lane i with b_wr_strobe[i]=1 is written at the clock edge. b_wr_strobe=0 leaves the word unchanged. Writes are ignored while rst is high.
- Read: a read request at edge N samples the array. Data appears at the output after RD_LATENCY edges.
- The read output holds its last value between reads; only rd_valid pulses.
- Port B read and write in the same cycle:
  - RAM_READ_FIRST: b_rd_data returns the pre-write word.
  - RAM_WRITE_FIRST: b_rd_data returns the merged word (new strobed bytes, old unstrobed bytes).
- Cross-port collision (A read and B write to the same address in the same cycle): the same COLLISION rule applies to a_rd_data, per byte lane. WRITE_FIRST is implemented as a bypass mux on the registered read.
- Reads to different addresses are independent; both ports can read every cycle.
- Reset:
  - a_rd_data, b_rd_data, a_rd_valid, b_rd_valid and parity_err all reset to 0.
  - Reads in flight when rst is asserted are dropped; no valid pulse is produced for them.
  - A read request in the reset cycle is ignored.

## Timing
- RD_LATENCY=1: request at edge N → data and valid after edge N, i.e. usable in cycle N+1.
- RD_LATENCY=2: a second output register stage is added → data usable in cycle N+2.
- Both ports are fully pipelined: one request per cycle per port. There is no backpressure or stall input.
- Write-then-read on consecutive cycles to the same address returns the new data, regardless of COLLISION.
- rd_valid deasserts in the cycle after a pulse unless another request was made.

## Configuration
- RAM_PARITY_EN defined:
  - Each byte stores one extra even-parity bit, computed at write.
  - Parity is checked on every read at the first pipeline stage.
  - A mismatch on any byte of any port sets parity_err, which stays high until rst. Read data is still delivered unmodified.
  - For uninitialised words, parity is not guaranteed; software must write before reading.
- RAM_PARITY_EN undefined: no parity storage, no check logic, and the parity_err port is absent.

## Structure
- In package lexington: ram_collision_t (RAM_READ_FIRST, RAM_WRITE_FIRST), RAM_MAX_RD_LATENCY = 2, and the existing DEFAULT_RAM_ADDR_WIDTH.
- One sub-module, ram_rd_pipe, instantiated once per port. It holds the RD_LATENCY-deep data/valid register chain, the collision bypass mux and the parity check.
- The array is inferred in ram_dual as a true dual-port block RAM; keep_hierarchy is retained.

## Test plan
- Reset and latency: with RD_LATENCY=1, write 0xDEADBEEF to addr 5, then read it on port A → a_rd_valid pulses one cycle later with 0xDEADBEEF. Assert rst → all outputs are 0 on the next cycle.
- Byte strobes: write 0x11223344 to addr 3, then write 0xAABBCCDD with strobe 4'b0101 → a read returns 0x11BB33DD.
- Collision: addr 7 holds 0x0; in one cycle, A reads and B writes 0xCAFEF00D (strobe 4'hF). With READ_FIRST, both a_rd_data and b_rd_data return 0x0. With WRITE_FIRST, both return 0xCAFEF00D.
- Pipelining: with RD_LATENCY=2, issue back-to-back port A reads of addrs 0..7 (preloaded with value = addr) → eight consecutive valid pulses carrying 0..7, starting two cycles after the first request.
- Reset mid-operation: with RD_LATENCY=2, issue a read, assert rst on the next cycle → no valid pulse is produced, and a_rd_data stays 0.
- Parity (with RAM_PARITY_EN): write 0x000000FF, force-flip bit 0 of the stored word, then read → parity_err goes to 1 and stays 1 until rst. The same flow without the flip leaves parity_err at 0.
